// File: rtl/mul_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : mul_ctrl
// Purpose  : Sequencer for a repeated-addition multiplier datapath: fetches
//            operands A and B over valid/ready, then adds A into P B times.
// Revision : 1.0 - initial release
// ============================================================================
module mul_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             eqz,
  output logic [WIDTH-1:0] bus_data,
  output logic             LdA,
  output logic             LdB,
  output logic             LdP,
  output logic             clrP,
  output logic             decB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_ADD    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_iter_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_iter_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_LOAD_A;
            r_iter_count <= '0;
          end
        end
        S_LOAD_A: begin
          if (abort)         r_state <= S_IDLE;
          else if (in_valid) r_state <= S_LOAD_B;
        end
        S_LOAD_B: begin
          if (abort)         r_state <= S_IDLE;
          else if (in_valid) r_state <= S_ADD;
        end
        S_ADD: begin
          // Abort outranks eqz; iter_count is frozen at whatever was reached.
          if (abort)    r_state <= S_IDLE;
          else if (eqz) r_state <= S_DONE;
          else          r_iter_count <= r_iter_count + WIDTH'(1);
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic             w_in_ready;
  logic [WIDTH-1:0] w_bus_data;
  logic             w_lda;
  logic             w_ldb;
  logic             w_ldp;
  logic             w_clrp;
  logic             w_decb;

  always_comb begin
    w_in_ready = 1'b0;
    w_bus_data = '0;
    w_lda      = 1'b0;
    w_ldb      = 1'b0;
    w_ldp      = 1'b0;
    w_clrp     = 1'b0;
    w_decb     = 1'b0;
    case (r_state)
      S_LOAD_A: begin
        w_bus_data = in_data;
        w_in_ready = !abort;
        w_lda      = in_valid && !abort;
      end
      S_LOAD_B: begin
        w_bus_data = in_data;
        w_in_ready = !abort;
        w_ldb      = in_valid && !abort;
        w_clrp     = in_valid && !abort;
      end
      S_ADD: begin
        w_ldp  = !eqz && !abort;
        w_decb = !eqz && !abort;
      end
      default: ;
    endcase
  end

  assign in_ready   = w_in_ready;
  assign bus_data   = w_bus_data;
  assign LdA        = w_lda;
  assign LdB        = w_ldb;
  assign LdP        = w_ldp;
  assign clrP       = w_clrp;
  assign decB       = w_decb;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign iter_count = r_iter_count;

endmodule
`default_nettype wire
